// File: rtl/sum_xchg_pkg.sv
// Shared types and sizing helpers for the partial-sum exchange hub.
package sum_xchg_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SUM,
      S_HOLD
   } state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   localparam int DEF_NCORE   = 2;
   localparam int DEF_BW_PSUM = 20;
   localparam int DEF_SW      = DEF_BW_PSUM + 4;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_OW      = DEF_SW + clog2(DEF_NCORE);
   localparam int DEF_PTR_W   = clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/sum_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one wrap bit so
// full and empty are distinguishable without a separate counter.
module sum_fifo
   import sum_xchg_pkg::*;
#(
   parameter int width = DEF_SW,
   parameter int depth = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_i,
   input  logic [width-1:0] din_i,
   input  logic             rd_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [width-1:0] dout_o
);

   localparam int aw = clog2(depth);
   localparam int pw = aw + 1;

   logic [width-1:0] mem_q [depth];
   logic [pw-1:0]    wr_ptr_q;
   logic [pw-1:0]    rd_ptr_q;
   logic             wr_en;
   logic             rd_en;

   assign full_o  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                    (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign wr_en   = wr_i && !full_o;
   assign rd_en   = rd_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q[aw-1:0]];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + pw'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + pw'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // words are valid, and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[aw-1:0]] <= din_i;
   end

endmodule

// File: rtl/sum_xchg_hub.sv
// Partial-sum exchange hub: buffers one sum per core, aligns a full set and
// returns each core either the sum of its peers or the global total.
module sum_xchg_hub
   import sum_xchg_pkg::*;
#(
   parameter int ncore   = DEF_NCORE,
   parameter int bw_psum = DEF_BW_PSUM,
   parameter int sw      = bw_psum + 4,
   parameter int depth   = DEF_DEPTH,
   parameter int ow      = sw + clog2(ncore)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ncore*sw-1:0] sum_in,
   input  logic [ncore-1:0]    sum_in_valid,
   output logic [ncore-1:0]    sum_in_ready,
   input  logic                mode,
   output logic [ncore*ow-1:0] sum_out,
   output logic [ncore-1:0]    sum_out_valid,
   input  logic [ncore-1:0]    sum_out_rd,
   output logic [ncore-1:0]    ovf,
   output logic                busy
);

   logic [ncore-1:0] fifo_full;
   logic [ncore-1:0] fifo_empty;
   logic [sw-1:0]    fifo_dout [ncore];
   logic [ow-1:0]    tot_sum;
   logic             pop;

   state_e           state_q, state_d;
   logic [sw-1:0]    v_q [ncore];
   logic [sw-1:0]    v_d [ncore];
   logic [ow-1:0]    res_q [ncore];
   logic [ow-1:0]    res_d [ncore];
   logic [ow-1:0]    tot_q, tot_d;
   logic             mode_q, mode_d;
   logic [ncore-1:0] valid_q, valid_d;
   logic [ncore-1:0] ovf_q;

   // A set is taken only when every core has a word and no result is pending.
   assign pop = (state_q == S_IDLE) && (fifo_empty == '0) && (valid_q == '0);

   for (genvar i = 0; i < ncore; i++) begin : g_core
      sum_fifo #(
         .width (sw),
         .depth (depth)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr_i    (sum_in_valid[i]),
         .din_i   (sum_in[i*sw +: sw]),
         .rd_i    (pop),
         .full_o  (fifo_full[i]),
         .empty_o (fifo_empty[i]),
         .dout_o  (fifo_dout[i])
      );
      assign sum_out[i*ow +: ow] = res_q[i];
   end

   // NOTE: blocking accumulation is intended here; each iteration must see the
   // partial sum written by the previous one within the same evaluation.
   always_comb begin
      tot_sum = '0;
      for (int i = 0; i < ncore; i++) begin
         tot_sum = tot_sum + ow'(fifo_dout[i]);
      end
   end

   // NOTE: every next-state signal is defaulted first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      res_d   = res_q;
      tot_d   = tot_q;
      mode_d  = mode_q;
      valid_d = valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               v_d     = fifo_dout;
               tot_d   = tot_sum;
               mode_d  = mode;
               state_d = S_SUM;
            end
         end
         S_SUM: begin
            for (int i = 0; i < ncore; i++) begin
               res_d[i] = mode_q ? tot_q : tot_q - ow'(v_q[i]);
            end
            valid_d = '1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            valid_d = valid_q & ~sum_out_rd;
            if (valid_d == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         tot_q   <= '0;
         mode_q  <= 1'b0;
         valid_q <= '0;
         ovf_q   <= '0;
         for (int i = 0; i < ncore; i++) begin
            v_q[i]   <= '0;
            res_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         tot_q   <= tot_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_q | (sum_in_valid & fifo_full);
         for (int i = 0; i < ncore; i++) begin
            v_q[i]   <= v_d[i];
            res_q[i] <= res_d[i];
         end
      end
   end

   assign sum_in_ready  = ~fifo_full;
   assign sum_out_valid = valid_q;
   assign ovf           = ovf_q;
   assign busy          = (state_q != S_IDLE) || !(&fifo_empty);

endmodule

// File: tb/tb_sum_xchg_hub.sv
// Directed bench for sum_xchg_hub: a two-core and a four-core instance share
// clock and reset; each scenario task checks its own hand-computed results.
module tb_sum_xchg_hub;

   localparam int SW  = 24;
   localparam int OW2 = 25;
   localparam int OW4 = 26;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [2*SW-1:0]  sum_in2;
   logic [1:0]       in_valid2, in_ready2, out_valid2, out_rd2, ovf2;
   logic             mode2, busy2;
   logic [2*OW2-1:0] sum_out2;

   logic [4*SW-1:0]  sum_in4;
   logic [3:0]       in_valid4, in_ready4, out_valid4, out_rd4, ovf4;
   logic             mode4, busy4;
   logic [4*OW4-1:0] sum_out4;

   int n_checks = 0;
   int n_fail   = 0;

   sum_xchg_hub #(.ncore(2)) u_dut2 (
      .clk           (clk),
      .reset         (reset),
      .sum_in        (sum_in2),
      .sum_in_valid  (in_valid2),
      .sum_in_ready  (in_ready2),
      .mode          (mode2),
      .sum_out       (sum_out2),
      .sum_out_valid (out_valid2),
      .sum_out_rd    (out_rd2),
      .ovf           (ovf2),
      .busy          (busy2)
   );

   sum_xchg_hub #(.ncore(4)) u_dut4 (
      .clk           (clk),
      .reset         (reset),
      .sum_in        (sum_in4),
      .sum_in_valid  (in_valid4),
      .sum_in_ready  (in_ready4),
      .mode          (mode4),
      .sum_out       (sum_out4),
      .sum_out_valid (out_valid4),
      .sum_out_rd    (out_rd4),
      .ovf           (ovf4),
      .busy          (busy4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push4(input logic [3:0] vmask, input logic [SW-1:0] a, b, c, d);
      sum_in4   = {d, c, b, a};
      in_valid4 = vmask;
      tick();
      in_valid4 = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      n_checks++;
      if (sum_out4 !== '0 || out_valid4 !== 4'b0 || ovf4 !== 4'b0 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut4: out=%0h valid=%b ovf=%b busy=%b, required all zero",
                  sum_out4, out_valid4, ovf4, busy4);
      end
      n_checks++;
      if (in_ready4 !== 4'hF || in_ready2 !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_ready: ready4=%b ready2=%b, required all ones", in_ready4, in_ready2);
      end
      n_checks++;
      if (sum_out2 !== '0 || out_valid2 !== 2'b0 || ovf2 !== 2'b0 || busy2 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut2: out=%0h valid=%b ovf=%b busy=%b, required all zero",
                  sum_out2, out_valid2, ovf2, busy2);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_peer_two_core();
      mode2     = 1'b0;
      out_rd2   = 2'b11;
      sum_in2   = {24'd250, 24'd100};
      in_valid2 = 2'b11;
      tick();
      in_valid2 = 2'b00;
      n_checks++;
      if (busy2 !== 1'b1) begin
         n_fail++;
         $display("FAIL peer2_busy: got %b required 1", busy2);
      end
      tick();
      n_checks++;
      if (out_valid2 !== 2'b00) begin
         n_fail++;
         $display("FAIL peer2_early_valid: got %b required 00", out_valid2);
      end
      tick();
      n_checks++;
      if (out_valid2 !== 2'b11 || sum_out2[0 +: OW2] !== 25'd250 || sum_out2[OW2 +: OW2] !== 25'd100) begin
         n_fail++;
         $display("FAIL peer2_result: valid=%b out0=%0d out1=%0d, required 11/250/100",
                  out_valid2, sum_out2[0 +: OW2], sum_out2[OW2 +: OW2]);
      end
      tick();
      n_checks++;
      if (out_valid2 !== 2'b00 || busy2 !== 1'b0 || sum_out2[0 +: OW2] !== 25'd250) begin
         n_fail++;
         $display("FAIL peer2_one_cycle: valid=%b busy=%b out0=%0d, required 00/0/250",
                  out_valid2, busy2, sum_out2[0 +: OW2]);
      end
   endtask

   task automatic test_global_four();
      mode4   = 1'b1;
      out_rd4 = 4'hF;
      push4(4'b0001, 24'd1, 24'd0, 24'd0, 24'd0);
      push4(4'b0010, 24'd0, 24'd2, 24'd0, 24'd0);
      push4(4'b0100, 24'd0, 24'd0, 24'd3, 24'd0);
      n_checks++;
      if (out_valid4 !== 4'b0 || busy4 !== 1'b1) begin
         n_fail++;
         $display("FAIL global_no_early_pop: valid=%b busy=%b, required 0000/1", out_valid4, busy4);
      end
      push4(4'b1000, 24'd0, 24'd0, 24'd0, 24'd4);
      tick();
      n_checks++;
      if (out_valid4 !== 4'b0) begin
         n_fail++;
         $display("FAIL global_early_valid: got %b required 0000", out_valid4);
      end
      tick();
      n_checks++;
      if (out_valid4 !== 4'hF) begin
         n_fail++;
         $display("FAIL global_valid: got %b required 1111", out_valid4);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (sum_out4[i*OW4 +: OW4] !== 26'd10) begin
            n_fail++;
            $display("FAIL global_sum[%0d]: got %0d required 10", i, sum_out4[i*OW4 +: OW4]);
         end
      end
      tick();
      n_checks++;
      if (out_valid4 !== 4'b0) begin
         n_fail++;
         $display("FAIL global_clear: got %b required 0000", out_valid4);
      end
   endtask

   task automatic test_backpressure();
      logic [OW4-1:0] exp_a [4];
      exp_a = '{26'd90, 26'd80, 26'd70, 26'd60};
      mode4   = 1'b0;
      out_rd4 = 4'b1101;
      push4(4'hF, 24'd10, 24'd20, 24'd30, 24'd40);
      sum_in4   = {24'd4, 24'd3, 24'd2, 24'd1};
      in_valid4 = 4'hF;
      tick();
      in_valid4 = '0;
      mode4     = 1'b1;
      tick();
      n_checks++;
      if (out_valid4 !== 4'hF) begin
         n_fail++;
         $display("FAIL bp_valid: got %b required 1111", out_valid4);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (sum_out4[i*OW4 +: OW4] !== exp_a[i]) begin
            n_fail++;
            $display("FAIL bp_peer_sum[%0d]: got %0d required %0d", i, sum_out4[i*OW4 +: OW4], exp_a[i]);
         end
      end
      tick();
      n_checks++;
      if (out_valid4 !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_partial_read: got %b required 0010", out_valid4);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (out_valid4 !== 4'b0010 || sum_out4[OW4 +: OW4] !== 26'd80 || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d: valid=%b out1=%0d busy=%b, required 0010/80/1",
                     k, out_valid4, sum_out4[OW4 +: OW4], busy4);
         end
      end
      n_checks++;
      if (sum_out4[0 +: OW4] !== 26'd90) begin
         n_fail++;
         $display("FAIL bp_out0_stable: got %0d required 90", sum_out4[0 +: OW4]);
      end
      out_rd4 = 4'hF;
      tick();
      n_checks++;
      if (out_valid4 !== 4'b0) begin
         n_fail++;
         $display("FAIL bp_release: got %b required 0000", out_valid4);
      end
      tick();
      n_checks++;
      if (out_valid4 !== 4'b0) begin
         n_fail++;
         $display("FAIL bp_second_early: got %b required 0000", out_valid4);
      end
      tick();
      n_checks++;
      if (out_valid4 !== 4'hF) begin
         n_fail++;
         $display("FAIL bp_second_valid: got %b required 1111", out_valid4);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (sum_out4[i*OW4 +: OW4] !== 26'd10) begin
            n_fail++;
            $display("FAIL bp_second_sum[%0d]: got %0d required 10", i, sum_out4[i*OW4 +: OW4]);
         end
      end
      tick();
      n_checks++;
      if (out_valid4 !== 4'b0 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle: valid=%b busy=%b required 0000/0", out_valid4, busy4);
      end
   endtask

   task automatic test_overflow();
      logic [OW4-1:0] exp_o [4];
      int got;
      exp_o = '{26'd14, 26'd15, 26'd16, 26'd17};
      got   = 0;
      mode4   = 1'b1;
      out_rd4 = 4'hF;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (in_ready4[0] !== (k < 4)) begin
            n_fail++;
            $display("FAIL ovf_ready before push %0d: got %b required %b", k, in_ready4[0], (k < 4));
         end
         push4(4'b0001, SW'(11 + k), 24'd0, 24'd0, 24'd0);
      end
      n_checks++;
      if (ovf4 !== 4'b0001 || in_ready4 !== 4'b1110) begin
         n_fail++;
         $display("FAIL ovf_set: ovf=%b ready=%b required 0001/1110", ovf4, in_ready4);
      end
      for (int c = 0; c < 40; c++) begin
         if (c < 4) begin
            sum_in4   = {24'd1, 24'd1, 24'd1, 24'd0};
            in_valid4 = 4'b1110;
         end else begin
            in_valid4 = 4'b0;
         end
         tick();
         if (out_valid4[0]) begin
            n_checks++;
            if (got >= 4) begin
               n_fail++;
               $display("FAIL ovf_extra_result: got %0d, required no fifth result", sum_out4[0 +: OW4]);
            end else if (sum_out4[0 +: OW4] !== exp_o[got]) begin
               n_fail++;
               $display("FAIL ovf_drain[%0d]: got %0d required %0d", got, sum_out4[0 +: OW4], exp_o[got]);
            end
            got++;
         end
      end
      in_valid4 = 4'b0;
      n_checks++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL ovf_drain_count: got %0d results required 4", got);
      end
      n_checks++;
      if (ovf4 !== 4'b0001 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_sticky: ovf=%b busy=%b required 0001/0", ovf4, busy4);
      end
   endtask

   task automatic test_max_value();
      out_rd4 = 4'hF;
      mode4   = 1'b1;
      push4(4'hF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid4[i] !== 1'b1 || sum_out4[i*OW4 +: OW4] !== 26'h3FFFFFC) begin
            n_fail++;
            $display("FAIL max_global[%0d]: valid=%b got %0h required 3fffffc",
                     i, out_valid4[i], sum_out4[i*OW4 +: OW4]);
         end
      end
      tick();
      mode4 = 1'b0;
      push4(4'hF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid4[i] !== 1'b1 || sum_out4[i*OW4 +: OW4] !== 26'h2FFFFFD) begin
            n_fail++;
            $display("FAIL max_peer[%0d]: valid=%b got %0h required 2fffffd",
                     i, out_valid4[i], sum_out4[i*OW4 +: OW4]);
         end
      end
      tick();
   endtask

   task automatic test_reset_in_hold();
      logic [OW4-1:0] exp_f [4];
      exp_f = '{26'd27, 26'd26, 26'd25, 26'd24};
      mode4   = 1'b0;
      out_rd4 = 4'b0;
      push4(4'hF, 24'd5, 24'd6, 24'd7, 24'd8);
      push4(4'b0011, 24'd1, 24'd1, 24'd0, 24'd0);
      tick();
      n_checks++;
      if (out_valid4 !== 4'hF || busy4 !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_hold_setup: valid=%b busy=%b required 1111/1", out_valid4, busy4);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (sum_out4 !== '0 || out_valid4 !== 4'b0 || ovf4 !== 4'b0 || busy4 !== 1'b0 || in_ready4 !== 4'hF) begin
         n_fail++;
         $display("FAIL rst_hold_clear: out=%0h valid=%b ovf=%b busy=%b ready=%b, required 0/0000/0000/0/1111",
                  sum_out4, out_valid4, ovf4, busy4, in_ready4);
      end
      #2 reset = 1'b0;
      tick();
      out_rd4 = 4'hF;
      push4(4'hF, 24'd7, 24'd8, 24'd9, 24'd10);
      tick();
      tick();
      n_checks++;
      if (out_valid4 !== 4'hF) begin
         n_fail++;
         $display("FAIL rst_fresh_valid: got %b required 1111", out_valid4);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (sum_out4[i*OW4 +: OW4] !== exp_f[i]) begin
            n_fail++;
            $display("FAIL rst_fresh_sum[%0d]: got %0d required %0d", i, sum_out4[i*OW4 +: OW4], exp_f[i]);
         end
      end
      tick();
      n_checks++;
      if (out_valid4 !== 4'b0 || busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_fresh_idle: valid=%b busy=%b required 0000/0", out_valid4, busy4);
      end
   endtask

   initial begin
      reset     = 1'b1;
      sum_in2   = '0;
      in_valid2 = '0;
      out_rd2   = '0;
      mode2     = 1'b0;
      sum_in4   = '0;
      in_valid4 = '0;
      out_rd4   = '0;
      mode4     = 1'b0;
      test_reset();
      test_peer_two_core();
      test_global_four();
      test_backpressure();
      test_overflow();
      test_max_value();
      test_reset_in_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sum_xchg_hub.md
Name: sum_xchg_hub

Overview:
- Parametrised N-core partial-sum exchange hub; replaces the hardwired two-core cross-connect and tie-high sfp_sum_fifo_rd at the multi-core top level.
- Each core pushes its local normalisation sum. The hub buffers these per core and aligns one entry from every core.
- Per core, the hub returns either the sum of all peer cores or the global total.
- Consumption uses a real valid/rd handshake.

Parameters:
- ncore, 2, number of cores attached (≥2)
- bw_psum, 20, core psum width
- sw, bw_psum+4, width of each core's sum_out word (unsigned)
- depth, 4, per-core input FIFO depth (power of 2, ≥2)
- ow, sw+$clog2(ncore), output sum width; never overflows

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- sum_in  input  ncore*sw  core i sum at [i*sw +: sw]
- sum_in_valid  input  ncore  core i push strobe
- sum_in_ready  output  ncore  core i FIFO not full
- mode  input  1  0 = peer sum (exclude own), 1 = global total
- sum_out  output  ncore*ow  result for core i at [i*ow +: ow]
- sum_out_valid  output  ncore  result for core i pending
- sum_out_rd  input  ncore  core i consumes its result
- ovf  output  ncore  sticky: push dropped while FIFO full
- busy  output  1  high when state != S_IDLE or any FIFO non-empty

Behaviour:
- Reset (async, mid-operation included):
  - All FIFOs emptied; state = S_IDLE; latched values cleared.
  - sum_out = 0, sum_out_valid = 0, ovf = 0, busy = 0.
  - sum_in_ready = all ones.
- Push:
  - Write to FIFO i when sum_in_valid[i] && !full[i].
  - If full[i], the word is dropped and ovf[i] sets. ovf clears only on reset.
  - sum_in_ready[i] = !full[i], combinational from FIFO state.
- FSM states:
  - S_IDLE: when every FIFO is non-empty and no sum_out_valid bit is set, pop one entry from every FIFO on the same edge. Latch the values v[i], tot = Σ v[i] (ow bits), and mode. Go to S_SUM. Otherwise stay.
  - S_SUM: for each i, load sum_out[i] = latched_mode ? tot : tot − v[i]. Set all sum_out_valid. Go to S_HOLD.
  - S_HOLD:
    - sum_out_valid[i] clears on an edge where sum_out_rd[i] = 1; sum_out[i] holds its value.
    - Return to S_IDLE on the edge where the last valid bit clears.
    - rd while valid = 0 is ignored.
- Latency:
  - Last required push sampled at edge E0 → pop at E1 → sum_out_valid high after E2.
  - Best-case throughput is one result per 3 cycles, with every core reading in the first S_HOLD cycle.
- Pushes during S_SUM or S_HOLD are accepted into the FIFOs. They are not consumed until the next S_IDLE pop.
- A push and the pop on the same edge for the same FIFO are both honoured; occupancy is unchanged.
- A push is accepted when the FIFO is full and popping on that edge only if ready was high, i.e. pop does not bypass full.
- Arithmetic:
  - Unsigned zero-extended addition to ow bits.
  - tot − v[i] ≥ 0 always, so no saturation is needed.
- FIFO pointer wrap: depth-modulo pointers plus an extra bit for full/empty discrimination.
- mode is sampled only at the S_IDLE pop edge. Changes at any other time have no effect on in-flight results.

Decomposition:
- Package sum_xchg_pkg:
  - state enum {S_IDLE, S_SUM, S_HOLD}
  - function clog2
  - localparams for ow and the FIFO pointer width
- One sub-module, sum_fifo: a sync FIFO parametrised by width and depth with wr, rd, full, empty and dout (first-word-fall-through). sum_xchg_hub instantiates it ncore times via generate.
- Adder: a generate-loop sum in the top block; no sub-module.

Test Plan:
1. Two-core peer mode: ncore=2, mode=0, push core0=100 at E0 and core1=250 at E0, rd tied 1 → at E2 sum_out0=250, sum_out1=100, both valid for exactly 1 cycle.
2. Four-core global mode: ncore=4, mode=1, push 1, 2, 3, 4 staggered over 4 cycles → 2 cycles after the last push, all four outputs = 10. No pop occurs before the 4th push.
3. Backpressure: core1 rd held 0 for 10 cycles with a second set of pushes queued → first result stays valid and stable. No second pop happens. busy=1. Releasing rd gives the second result 3 cycles later.
4. Overflow: depth=4, core0 pushes 5 words while core1 pushes none → sum_in_ready[0] falls after 4 pushes. 5th word dropped, ovf[0]=1 and stays set. Results then drain in order.
5. Max value: sw=24, ncore=4, all pushes 24'hFFFFFF, mode=1 → sum_out = 26'h3FFFFFC with no truncation. mode=0 → 26'h2FFFFFD.
6. Reset in S_HOLD with FIFOs partly full → outputs, valids, ovf and FIFOs are cleared immediately. A subsequent fresh exchange gives correct sums.
